// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encoding,
// default reset PC and the NOP word shown while no instruction is held.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    // ST_ERR is only reachable when alignment checking is compiled in.
    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } ifu_state_e;

    // Word-aligned view of a byte address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_ctrl.sv
// Fetch control FSM: sequences BOOT -> REQ -> (WAIT) -> HOLD -> REQ and
// decodes the memory and decode handshakes into datapath load strobes.
// Optional macro IFU_ALIGN_CHK_EN adds the misaligned-next-PC trap state.
module ifu_ctrl
    import ifu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic imem_gnt,
    input  logic imem_rvalid,
    input  logic inst_ready,
`ifdef IFU_ALIGN_CHK_EN
    input  logic npc_misaligned,
    output logic fetch_err,
`endif
    output logic imem_req,
    output logic capture,
    output logic accept,
    output logic inst_valid
);

    ifu_state_e state;

    // Request and load strobes decode directly from the current state.
    assign imem_req = (state == ST_REQ);
    assign capture  = ((state == ST_REQ) && imem_gnt && imem_rvalid) ||
                      ((state == ST_WAIT) && imem_rvalid);
    assign accept   = (state == ST_HOLD) && inst_ready;

    // State register plus registered inst_valid / fetch_err.
    // NOTE: state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            inst_valid <= 1'b0;
`ifdef IFU_ALIGN_CHK_EN
            fetch_err  <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_BOOT: state <= ST_REQ;
                ST_REQ: begin
                    if (imem_gnt) begin
                        if (imem_rvalid) begin
                            state      <= ST_HOLD;
                            inst_valid <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state      <= ST_HOLD;
                        inst_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
`ifdef IFU_ALIGN_CHK_EN
                        if (npc_misaligned) begin
                            state     <= ST_ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                        end
`else
                        state <= ST_REQ;
`endif
                    end
                end
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit top: owns the PC, held instruction, its PC and the
// retired-fetch counter; ifu_ctrl sequences the handshakes.
// Optional macro IFU_ALIGN_CHK_EN adds fetch_err and traps on a misaligned
// next PC; otherwise the low PC bits are dropped on the fetch address.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_in,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
`ifdef IFU_ALIGN_CHK_EN
    output logic        fetch_err,
`endif
    output logic [31:0] fetch_cnt
);

    logic capture;
    logic accept;

    ifu_ctrl u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .inst_ready     (inst_ready),
`ifdef IFU_ALIGN_CHK_EN
        .npc_misaligned (npc_in[1:0] != 2'b00),
        .fetch_err      (fetch_err),
`endif
        .imem_req       (imem_req),
        .capture        (capture),
        .accept         (accept),
        .inst_valid     (inst_valid)
    );

    // Fetch address follows the PC register directly.
`ifdef IFU_ALIGN_CHK_EN
    assign imem_addr = pc_out;
`else
    assign imem_addr = word_align(pc_out);
`endif

    // Datapath registers: PC commits on decode handshake, instruction and its
    // PC load on memory capture and drop back to NOP once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out    <= RESET_PC;
            inst      <= NOP_WORD;
            inst_pc   <= RESET_PC;
            fetch_cnt <= '0;
        end else begin
            if (capture) begin
                inst    <= imem_rdata;
                inst_pc <= pc_out;
            end
            if (accept) begin
                pc_out    <= npc_in;
                inst      <= NOP_WORD;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule
